vedic_seq_divider: RTL and testbench

Multi-cycle restoring divider, the inverse of the 2x2 Vedic multiplier. It accepts a WIDTH-bit dividend (default: the 4-bit product) and a DIV_WIDTH-bit divisor (default: a 2-bit operand). It returns quotient and remainder after one iteration per dividend bit. It sits beside the multiplier in the arithmetic datapath and uses valid/ready handshakes on both sides.

---
 rtl/vedic_arith_pkg.sv | 25 ++
 rtl/vedic_seq_divider_if.sv | 35 +++
 rtl/vedic_div_step.sv | 31 +++
 rtl/vedic_seq_divider.sv | 126 ++++++++++++
 tb/tb_vedic_seq_divider.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/vedic_arith_pkg.sv
// -----------------------------------------------------------------------------
// vedic_arith_pkg
// Shared definitions for the Vedic arithmetic datapath (multiplier and divider).
//   div_state_t       : divider FSM states.
//   DIV_ZERO_QUOTIENT : all-ones quotient returned for a zero divisor.
//                       Callers slice it down to their own width.
//   widths_ok()       : elaboration-time operand width sanity check.
// -----------------------------------------------------------------------------
package vedic_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic [63:0] DIV_ZERO_QUOTIENT = '1;

  // The narrow operand must be non-empty and no wider than the wide one.
  // The wide operand must fit DIV_ZERO_QUOTIENT.
  function automatic bit widths_ok(input int unsigned wide, input int unsigned narrow);
    return (narrow >= 1) && (narrow <= wide) && (wide <= 64);
  endfunction

endpackage

// File: rtl/vedic_seq_divider_if.sv
// -----------------------------------------------------------------------------
// vedic_seq_divider_if
// Operand and result handshake bundle for vedic_seq_divider.
//   in_valid/in_ready   : operand handshake (dividend, divisor)
//   out_valid/out_ready : result handshake (quotient, remainder, div_zero)
// Modports:
//   master : the producer/consumer of the divider (drives operands, out_ready)
//   slave  : the divider itself
// -----------------------------------------------------------------------------
interface vedic_seq_divider_if #(
  parameter int WIDTH     = 4,
  parameter int DIV_WIDTH = 2
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     dividend;
  logic [DIV_WIDTH-1:0] divisor;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     quotient;
  logic [DIV_WIDTH-1:0] remainder;
  logic                 div_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero
  );

endinterface

// File: rtl/vedic_div_step.sv
// -----------------------------------------------------------------------------
// vedic_div_step
// One combinational restoring-division step.
//   rem_i      : partial remainder so far (always < divisor_i)
//   next_bit_i : next dividend bit, shifted into the partial remainder
//   divisor_i  : non-zero divisor
//   new_rem_o  : updated partial remainder
//   q_bit_o    : quotient bit produced by this step
// -----------------------------------------------------------------------------
module vedic_div_step #(
  parameter int DIV_WIDTH = 2
) (
  input  logic [DIV_WIDTH-1:0] rem_i,
  input  logic                 next_bit_i,
  input  logic [DIV_WIDTH-1:0] divisor_i,
  output logic [DIV_WIDTH-1:0] new_rem_o,
  output logic                 q_bit_o
);

  logic [DIV_WIDTH:0]   partial;
  logic [DIV_WIDTH-1:0] diff;

  assign partial = {rem_i, next_bit_i};
  assign q_bit_o = (partial >= {1'b0, divisor_i});

  // Because rem_i < divisor_i, partial - divisor_i < divisor_i whenever the
  // subtraction is taken, so the low DIV_WIDTH bits carry the exact result.
  assign diff      = partial[DIV_WIDTH-1:0] - divisor_i;
  assign new_rem_o = q_bit_o ? diff : partial[DIV_WIDTH-1:0];

endmodule

// File: rtl/vedic_seq_divider.sv
// -----------------------------------------------------------------------------
// vedic_seq_divider
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, aborts any division in flight
//   bus   : vedic_seq_divider_if.slave
//           dividend/divisor in on in_valid && in_ready,
//           quotient/remainder/div_zero out on out_valid && out_ready.
// A non-zero divisor yields a result WIDTH clocks after the accept edge.
// A zero divisor goes straight to DONE with an all-ones quotient and div_zero
// set, so its result is valid in the cycle right after the accept.
// -----------------------------------------------------------------------------
module vedic_seq_divider
  import vedic_arith_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DIV_WIDTH = 2
) (
  input logic                clk,
  input logic                rst_n,
  vedic_seq_divider_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (!widths_ok(WIDTH, DIV_WIDTH)) begin : g_width_err
    $error("vedic_seq_divider: DIV_WIDTH must be in 1..WIDTH and WIDTH <= 64");
  end

  div_state_t           state_q,   state_d;
  logic [WIDTH-1:0]     shift_q,   shift_d;    // dividend in, quotient out
  logic [DIV_WIDTH-1:0] rem_q,     rem_d;
  logic [DIV_WIDTH-1:0] divisor_q, divisor_d;
  logic [CW-1:0]        count_q,   count_d;
  logic                 div_zero_q, div_zero_d;

  logic [DIV_WIDTH-1:0] step_rem;
  logic                 step_q_bit;

  vedic_div_step #(.DIV_WIDTH(DIV_WIDTH)) u_step (
    .rem_i      (rem_q),
    .next_bit_i (shift_q[WIDTH-1]),
    .divisor_i  (divisor_q),
    .new_rem_o  (step_rem),
    .q_bit_o    (step_q_bit)
  );

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    shift_d    = shift_q;
    rem_d      = rem_q;
    divisor_d  = divisor_q;
    count_d    = count_q;
    div_zero_d = div_zero_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.divisor != '0) begin
            shift_d    = bus.dividend;
            divisor_d  = bus.divisor;
            rem_d      = '0;
            count_d    = CW'(WIDTH - 1);
            div_zero_d = 1'b0;
            state_d    = BUSY;
          end else begin
            shift_d    = DIV_ZERO_QUOTIENT[WIDTH-1:0];
            rem_d      = '0;
            div_zero_d = 1'b1;
            state_d    = DONE;
          end
        end
      end

      BUSY: begin
        // Dividend bits leave at the MSB while quotient bits enter at the LSB,
        // so after WIDTH steps the register holds the full quotient.
        shift_d    = shift_q << 1;
        shift_d[0] = step_q_bit;
        rem_d      = step_rem;
        if (count_q == '0) begin
          state_d = DONE;
        end else begin
          count_d = count_q - CW'(1);
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      rem_q      <= '0;
      divisor_q  <= '0;
      count_q    <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      rem_q      <= rem_d;
      divisor_q  <= divisor_d;
      count_q    <= count_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.quotient  = shift_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_vedic_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_vedic_seq_divider
// Scoreboard bench: the driver pushes the expected result of every accepted
// operand pair; a negedge monitor compares each presented result against the
// head of the queue and pops it on the output handshake.
// -----------------------------------------------------------------------------
module tb_vedic_seq_divider;

  localparam int W  = 4;
  localparam int DW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  vedic_seq_divider_if #(.WIDTH(W), .DIV_WIDTH(DW)) bus ();

  vedic_seq_divider #(.WIDTH(W), .DIV_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0]  q;
    logic [DW-1:0] r;
    logic          dz;
    int            lat;      // posedges from accept edge to out_valid visible
    int            acc_cyc;
    bit            seen;
  } exp_t;

  exp_t sb[$];
  int   n_checks    = 0;
  int   n_fail      = 0;
  int   cyc         = 0;
  int   last_hs_cyc = -100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares every cycle the result is presented, which also
  // verifies the result is held stable while out_ready is low.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        if (!sb[0].seen) begin
          sb[0].seen = 1'b1;
          check("latency", cyc - sb[0].acc_cyc, sb[0].lat);
        end
        check("quotient",  bus.quotient,  sb[0].q);
        check("remainder", bus.remainder, sb[0].r);
        check("div_zero",  bus.div_zero,  sb[0].dz);
        if (bus.out_ready) begin
          last_hs_cyc = cyc + 1;
          void'(sb.pop_front());
        end
      end
    end
  end

  // Drive one operand pair, wait (bounded) for acceptance, optionally push
  // the expected result. Called and returns at posedge + 1.
  task automatic issue(input logic [W-1:0] a, input logic [DW-1:0] b,
                       input logic [W-1:0] eq, input logic [DW-1:0] er,
                       input logic edz, input bit push, output int acc);
    exp_t e;
    int   t = 0;
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) check("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    acc = cyc;
    if (push) begin
      e.q = eq; e.r = er; e.dz = edz;
      e.lat = edz ? 0 : W;
      e.acc_cyc = acc;
      e.seen = 1'b0;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_queue_empty", sb.size(), 0);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_in_ready"},  bus.in_ready,  1);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_quotient"},  bus.quotient,  0);
    check({tag, "_remainder"}, bus.remainder, 0);
    check({tag, "_div_zero"},  bus.div_zero,  0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int t;
    logic [W-1:0]  mq;
    logic [DW-1:0] mr;

    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: 9 / 2 = 4 r 1, result 4 cycles after accept
    issue(4'd9, 2'd2, 4'd4, 2'd1, 1'b0, 1'b1, acc);
    drain();

    // 2: back-to-back 15/3 = 5 r 0 then 2/3 = 0 r 2
    issue(4'd15, 2'd3, 4'd5, 2'd0, 1'b0, 1'b1, acc);
    issue(4'd2,  2'd3, 4'd0, 2'd2, 1'b0, 1'b1, acc);
    check("b2b_accept_after_handshake", (acc >= last_hs_cyc + 1), 1);
    drain();

    // 3: 7 / 0 -> all ones, r 0, div_zero
    issue(4'd7, 2'd0, 4'd15, 2'd0, 1'b1, 1'b1, acc);
    drain();

    // 4: 14 / 3 = 4 r 2 held with out_ready low; stray operands ignored
    bus.out_ready = 1'b0;
    issue(4'd14, 2'd3, 4'd4, 2'd2, 1'b0, 1'b1, acc);
    t = 0;
    while (!bus.out_valid && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("hold_out_valid_seen", bus.out_valid, 1);
    for (int i = 0; i < 6; i++) begin
      if (i == 1 || i == 3) begin
        bus.dividend = 4'd5;
        bus.divisor  = 2'd1;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      check("hold_in_ready",  bus.in_ready,  0);
      check("hold_out_valid", bus.out_valid, 1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("hold_no_stray_result", bus.out_valid, 0);

    // 5: reset in the second BUSY cycle of 13/2 aborts it
    issue(4'd13, 2'd2, 4'd0, 2'd0, 1'b0, 1'b0, acc);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_idle_zero("abort");
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_result", bus.out_valid, 0);
    issue(4'd13, 2'd2, 4'd6, 2'd1, 1'b0, 1'b1, acc);
    drain();

    // 6a: multiplier loopback, (a*b) / b = a r 0
    for (int a = 0; a < 4; a++) begin
      for (int b = 1; b < 4; b++) begin
        issue(W'(a * b), DW'(b), W'(a), '0, 1'b0, 1'b1, acc);
      end
    end
    drain();

    // 6b: all dividend/divisor pairs against the reference model
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 4; b++) begin
        mq = (b == 0) ? 4'd15 : W'(a / b);
        mr = (b == 0) ? 2'd0  : DW'(a % b);
        issue(W'(a), DW'(b), mq, mr, (b == 0), 1'b1, acc);
      end
    end
    drain();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
